// File: rtl/fm_sb_pkg.sv
// Shared types for the FM spy capture engine.
// Capture state and playback mode encodings.
package fm_sb_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_ARMED  = 3'd1,
        ST_POST   = 3'd2,
        ST_FROZEN = 3'd3,
        ST_PLAY   = 3'd4
    } fm_cap_state_t;

    // Mode 3 has no name: it behaves exactly like PB_PASS.
    typedef enum logic [1:0] {
        PB_PASS = 2'd0,
        PB_ONCE = 2'd1,
        PB_LOOP = 2'd2
    } fm_pb_mode_t;

    function automatic logic pb_mode_plays(input logic [1:0] mode);
        return (mode == PB_ONCE) || (mode == PB_LOOP);
    endfunction

endpackage

// File: rtl/fm_spy_capture_ch.sv
// One spy capture channel: arm/trigger/freeze FSM, capture memory,
// oldest-first playback and the passthrough/playback output stage.
module fm_spy_capture_ch
    import fm_sb_pkg::*;
#(
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10
) (
    input  logic              clk_hs,
    input  logic              rst_hs,
    input  logic [DATA_W-1:0] mon_data,
    input  logic              mon_vld,
    input  logic              arm,
    input  logic              trig,
    input  logic [ADDR_W-1:0] post_trig_cnt,
    input  logic [1:0]        pb_mode,
    input  logic              pb_start,
    input  logic              rb_en,
    input  logic [ADDR_W-1:0] rb_addr,
    output logic [DATA_W-1:0] rb_data,
    output logic [DATA_W-1:0] out_data,
    output logic              out_vld,
    output logic [2:0]        ch_state,
    output logic [ADDR_W-1:0] wr_ptr,
    output logic              wrapped
);

    localparam int DEPTH = 1 << ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_N = {1'b1, {ADDR_W{1'b0}}};
    localparam logic [ADDR_W:0] REM_ONE = (ADDR_W + 1)'(1);
    localparam logic [ADDR_W-1:0] CNT_ONE = ADDR_W'(1);

    fm_cap_state_t state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic              wrapped_q, wrapped_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;
    logic [ADDR_W-1:0] pb_ptr_q, pb_ptr_d;
    logic [ADDR_W-1:0] pb_base_q, pb_base_d;
    logic [ADDR_W:0]   pb_rem_q, pb_rem_d;
    logic [ADDR_W:0]   pb_len_q, pb_len_d;
    logic              pb_loop_q, pb_loop_d;
    logic              pb_iss_q, pb_iss_d;
    logic [DATA_W-1:0] out_data_q, out_data_d;
    logic              out_vld_q, out_vld_d;

    logic              wr_en;
    logic              pb_rd_en;
    logic [ADDR_W-1:0] play_base;
    logic [ADDR_W:0]   play_len;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [DATA_W-1:0] pa_rdata;
    logic [DATA_W-1:0] rb_data_q;

    // Oldest word sits at wr_ptr once the ring has wrapped, else at 0.
    assign play_base = wrapped_q ? wr_ptr_q : '0;
    assign play_len  = wrapped_q ? DEPTH_N : {1'b0, wr_ptr_q};

    // Next-state logic; arm outranks every other request in every state.
    always_comb begin
        state_d   = state_q;
        wr_ptr_d  = wr_ptr_q;
        wrapped_d = wrapped_q;
        cnt_d     = cnt_q;
        pb_ptr_d  = pb_ptr_q;
        pb_base_d = pb_base_q;
        pb_rem_d  = pb_rem_q;
        pb_len_d  = pb_len_q;
        pb_loop_d = pb_loop_q;
        pb_iss_d  = 1'b0;
        wr_en     = 1'b0;
        pb_rd_en  = 1'b0;
        if (arm) begin
            state_d   = ST_ARMED;
            wr_ptr_d  = '0;
            wrapped_d = 1'b0;
            cnt_d     = '0;
            pb_rem_d  = '0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                end
                ST_ARMED: begin
                    if (mon_vld) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (&wr_ptr_q) wrapped_d = 1'b1;
                    end
                    if (trig) begin
                        if (post_trig_cnt == '0) begin
                            state_d = ST_FROZEN;
                        end else begin
                            state_d = ST_POST;
                            cnt_d   = post_trig_cnt;
                        end
                    end
                end
                ST_POST: begin
                    if (mon_vld) begin
                        wr_en    = 1'b1;
                        wr_ptr_d = wr_ptr_q + 1'b1;
                        if (&wr_ptr_q) wrapped_d = 1'b1;
                        cnt_d = cnt_q - 1'b1;
                        if (cnt_q == CNT_ONE) state_d = ST_FROZEN;
                    end
                end
                ST_FROZEN: begin
                    if (pb_start && pb_mode_plays(pb_mode)
                        && play_len != '0) begin
                        state_d   = ST_PLAY;
                        pb_ptr_d  = play_base;
                        pb_base_d = play_base;
                        pb_rem_d  = play_len;
                        pb_len_d  = play_len;
                        pb_loop_d = (pb_mode == PB_LOOP);
                    end
                end
                ST_PLAY: begin
                    pb_rd_en = 1'b1;
                    pb_iss_d = 1'b1;
                    if (pb_rem_q == REM_ONE) begin
                        if (pb_loop_q) begin
                            pb_ptr_d = pb_base_q;
                            pb_rem_d = pb_len_q;
                        end else begin
                            state_d  = ST_FROZEN;
                            pb_rem_d = '0;
                        end
                    end else begin
                        pb_ptr_d = pb_ptr_q + 1'b1;
                        pb_rem_d = pb_rem_q - 1'b1;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // Output stage: playback words take precedence; an abort kills them.
    always_comb begin
        out_data_d = out_data_q;
        out_vld_d  = 1'b0;
        if (state_q == ST_PLAY && arm) begin
            out_vld_d = 1'b0;
        end else if (pb_iss_q) begin
            out_data_d = pa_rdata;
            out_vld_d  = 1'b1;
        end else if (state_q != ST_PLAY) begin
            out_data_d = mon_data;
            out_vld_d  = mon_vld;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            state_q    <= ST_IDLE;
            wr_ptr_q   <= '0;
            wrapped_q  <= 1'b0;
            cnt_q      <= '0;
            pb_ptr_q   <= '0;
            pb_base_q  <= '0;
            pb_rem_q   <= '0;
            pb_len_q   <= '0;
            pb_loop_q  <= 1'b0;
            pb_iss_q   <= 1'b0;
            out_data_q <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            wrapped_q  <= wrapped_d;
            cnt_q      <= cnt_d;
            pb_ptr_q   <= pb_ptr_d;
            pb_base_q  <= pb_base_d;
            pb_rem_q   <= pb_rem_d;
            pb_len_q   <= pb_len_d;
            pb_loop_q  <= pb_loop_d;
            pb_iss_q   <= pb_iss_d;
            out_data_q <= out_data_d;
            out_vld_q  <= out_vld_d;
        end
    end

    // Port A: capture write or playback read, never both by state.
    always_ff @(posedge clk_hs) begin
        if (wr_en) mem[wr_ptr_q] <= mon_data;
        if (pb_rd_en) pa_rdata <= mem[pb_ptr_q];
    end

    // Port B: random-access readout, old data on a same-cycle write.
    always_ff @(posedge clk_hs) begin
        if (rst_hs) rb_data_q <= '0;
        else if (rb_en) rb_data_q <= mem[rb_addr];
    end

    assign rb_data  = rb_data_q;
    assign out_data = out_data_q;
    assign out_vld  = out_vld_q;
    assign ch_state = state_q;
    assign wr_ptr   = wr_ptr_q;
    assign wrapped  = wrapped_q;

endmodule

// File: rtl/fm_spy_capture.sv
// Multi-channel trigger-aware spy capture engine for the FM path.
// Holds the channels plus the shared readout select and valid.
module fm_spy_capture
    import fm_sb_pkg::*;
#(
    parameter int N_CH   = 4,
    parameter int DATA_W = 64,
    parameter int ADDR_W = 10,
    parameter int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic                     clk_hs,
    input  logic                     rst_hs,
    input  logic [N_CH*DATA_W-1:0]   mon_data,
    input  logic [N_CH-1:0]          mon_vld,
    input  logic [N_CH-1:0]          arm,
    input  logic [N_CH-1:0]          trig,
    input  logic [ADDR_W-1:0]        post_trig_cnt,
    input  logic [2*N_CH-1:0]        pb_mode,
    input  logic [N_CH-1:0]          pb_start,
    input  logic                     rd_en,
    input  logic [CH_W-1:0]          rd_ch,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_vld,
    output logic [N_CH*DATA_W-1:0]   out_data,
    output logic [N_CH-1:0]          out_vld,
    output logic [3*N_CH-1:0]        ch_state,
    output logic [N_CH*ADDR_W-1:0]   wr_ptr,
    output logic [N_CH-1:0]          wrapped
);

    logic [DATA_W-1:0] rb_data [N_CH];
    logic [N_CH-1:0]   rb_en;
    logic              rd_ok;

    logic [CH_W-1:0] rd_sel_q, rd_sel_d;
    logic            rd_ok_q, rd_ok_d;
    logic            rd_vld_q, rd_vld_d;

    assign rd_ok = int'(rd_ch) < N_CH;

    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        assign rb_en[c] = rd_en && (rd_ch == CH_W'(c));

        fm_spy_capture_ch #(
            .DATA_W(DATA_W),
            .ADDR_W(ADDR_W)
        ) u_ch (
            .clk_hs       (clk_hs),
            .rst_hs       (rst_hs),
            .mon_data     (mon_data[c*DATA_W +: DATA_W]),
            .mon_vld      (mon_vld[c]),
            .arm          (arm[c]),
            .trig         (trig[c]),
            .post_trig_cnt(post_trig_cnt),
            .pb_mode      (pb_mode[2*c +: 2]),
            .pb_start     (pb_start[c]),
            .rb_en        (rb_en[c]),
            .rb_addr      (rd_addr),
            .rb_data      (rb_data[c]),
            .out_data     (out_data[c*DATA_W +: DATA_W]),
            .out_vld      (out_vld[c]),
            .ch_state     (ch_state[3*c +: 3]),
            .wr_ptr       (wr_ptr[c*ADDR_W +: ADDR_W]),
            .wrapped      (wrapped[c])
        );
    end

    // Remember which channel answers; hold it while no read is pending.
    always_comb begin
        rd_sel_d = rd_sel_q;
        rd_ok_d  = rd_ok_q;
        rd_vld_d = rd_en;
        if (rd_en) begin
            rd_sel_d = rd_ch;
            rd_ok_d  = rd_ok;
        end
    end

    // Readout select and valid registers.
    always_ff @(posedge clk_hs) begin
        if (rst_hs) begin
            rd_sel_q <= '0;
            rd_ok_q  <= 1'b0;
            rd_vld_q <= 1'b0;
        end else begin
            rd_sel_q <= rd_sel_d;
            rd_ok_q  <= rd_ok_d;
            rd_vld_q <= rd_vld_d;
        end
    end

    // Readout mux over the registered per-channel port-B words.
    always_comb begin
        rd_data = '0;
        for (int c = 0; c < N_CH; c++) begin
            if (rd_ok_q && rd_sel_q == CH_W'(c)) rd_data = rb_data[c];
        end
    end

    assign rd_vld = rd_vld_q;

endmodule

// File: tb/tb_fm_spy_capture.sv
// Scoreboard bench for fm_spy_capture (3 channels, 16-deep buffers).
// Channel 0 output and readout words are checked against queues.
module tb_fm_spy_capture;
    import fm_sb_pkg::*;

    localparam int N_CH   = 3;
    localparam int DATA_W = 64;
    localparam int ADDR_W = 4;
    localparam int CH_W   = 2;

    logic                    clk_hs = 1'b0;
    logic                    rst_hs;
    logic [N_CH*DATA_W-1:0]  mon_data;
    logic [N_CH-1:0]         mon_vld;
    logic [N_CH-1:0]         arm;
    logic [N_CH-1:0]         trig;
    logic [ADDR_W-1:0]       post_trig_cnt;
    logic [2*N_CH-1:0]       pb_mode;
    logic [N_CH-1:0]         pb_start;
    logic                    rd_en;
    logic [CH_W-1:0]         rd_ch;
    logic [ADDR_W-1:0]       rd_addr;
    logic [DATA_W-1:0]       rd_data;
    logic                    rd_vld;
    logic [N_CH*DATA_W-1:0]  out_data;
    logic [N_CH-1:0]         out_vld;
    logic [3*N_CH-1:0]       ch_state;
    logic [N_CH*ADDR_W-1:0]  wr_ptr;
    logic [N_CH-1:0]         wrapped;

    int n_cmp = 0;
    int n_bad = 0;
    logic [63:0] exp_out[$];
    logic [63:0] exp_rd[$];

    always #5 clk_hs = ~clk_hs;

    fm_spy_capture #(
        .N_CH(N_CH), .DATA_W(DATA_W), .ADDR_W(ADDR_W), .CH_W(CH_W)
    ) dut (
        .clk_hs(clk_hs), .rst_hs(rst_hs),
        .mon_data(mon_data), .mon_vld(mon_vld),
        .arm(arm), .trig(trig), .post_trig_cnt(post_trig_cnt),
        .pb_mode(pb_mode), .pb_start(pb_start),
        .rd_en(rd_en), .rd_ch(rd_ch), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_vld(rd_vld),
        .out_data(out_data), .out_vld(out_vld),
        .ch_state(ch_state), .wr_ptr(wr_ptr), .wrapped(wrapped)
    );

    task automatic chk(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_hs);
        #1;
    endtask

    function automatic logic [63:0] st(input int c);
        return 64'(ch_state[3*c +: 3]);
    endfunction

    function automatic logic [63:0] wp(input int c);
        return 64'(wr_ptr[c*ADDR_W +: ADDR_W]);
    endfunction

    // Drive one channel-0 word; passthrough is expected on out 0.
    task automatic word0(input logic [63:0] v, input logic t);
        mon_data[63:0] = v;
        mon_vld[0]     = 1'b1;
        trig[0]        = t;
        exp_out.push_back(v);
        tick();
        mon_vld[0] = 1'b0;
        trig[0]    = 1'b0;
    endtask

    task automatic rd(input int c, input int a, input logic [63:0] e);
        rd_en   = 1'b1;
        rd_ch   = CH_W'(c);
        rd_addr = ADDR_W'(a);
        exp_rd.push_back(e);
        tick();
        rd_en = 1'b0;
        chk("rd_lat", {63'd0, rd_vld}, 64'd1);
    endtask

    // Scoreboard side: pop on every valid word the DUT produces.
    always @(negedge clk_hs) begin
        if (out_vld[0] === 1'b1) begin
            if (exp_out.size() == 0)
                chk("out0_extra", {63'd0, out_vld[0]}, 64'd0);
            else
                chk("out0", out_data[63:0], exp_out.pop_front());
        end
        if (rd_vld === 1'b1) begin
            if (exp_rd.size() == 0)
                chk("rd_extra", {63'd0, rd_vld}, 64'd0);
            else
                chk("rd_data", rd_data, exp_rd.pop_front());
        end
    end

    initial begin
        rst_hs = 1'b1;
        mon_data = '0; mon_vld = '0; arm = '0; trig = '0;
        post_trig_cnt = '0; pb_mode = '0; pb_start = '0;
        rd_en = 1'b0; rd_ch = '0; rd_addr = '0;
        tick();
        tick();
        rst_hs = 1'b0;
        chk("rst_state", 64'(ch_state), 64'd0);
        chk("rst_wp", 64'(wr_ptr), 64'd0);
        chk("rst_wrap", 64'(wrapped), 64'd0);
        chk("rst_outv", 64'(out_vld), 64'd0);
        chk("rst_rdv", {63'd0, rd_vld}, 64'd0);
        chk("rst_rdd", rd_data, 64'd0);

        // Scenario 1: capture 1..8, trigger on 5 with 3 post words.
        post_trig_cnt = 4'd3;
        arm[0] = 1'b1;
        tick();
        arm[0] = 1'b0;
        chk("s1_armed", st(0), 64'(ST_ARMED));
        for (int i = 1; i <= 8; i++) begin
            word0(64'(i), i == 5);
            if (i == 1) begin
                chk("s1_pt_v", {63'd0, out_vld[0]}, 64'd1);
                chk("s1_pt_d", out_data[63:0], 64'd1);
            end
            if (i == 7) chk("s1_post", st(0), 64'(ST_POST));
        end
        chk("s1_frozen", st(0), 64'(ST_FROZEN));
        chk("s1_wp", wp(0), 64'd8);
        chk("s1_wrap", {63'd0, wrapped[0]}, 64'd0);
        word0(64'd100, 1'b0);
        word0(64'd101, 1'b0);
        chk("s1_nowr", wp(0), 64'd8);

        // Scenario 4: readout of the frozen capture, then a bad channel.
        for (int a = 0; a < 8; a++) rd(0, a, 64'(a + 1));
        tick();
        chk("s4_vld0", {63'd0, rd_vld}, 64'd0);
        chk("s4_hold", rd_data, 64'd8);
        rd(3, 0, 64'd0);
        tick();

        // Scenario 3: loop playback, aborted by arm after 19 words.
        pb_mode[1:0] = 2'd2;
        pb_start[0]  = 1'b1;
        for (int k = 0; k < 19; k++) exp_out.push_back(64'((k % 8) + 1));
        tick();
        pb_start[0] = 1'b0;
        chk("s3_play", st(0), 64'(ST_PLAY));
        chk("s3_d0", {63'd0, out_vld[0]}, 64'd0);
        tick();
        chk("s3_d1", {63'd0, out_vld[0]}, 64'd0);
        tick();
        chk("s3_first", {63'd0, out_vld[0]}, 64'd1);
        repeat (18) tick();
        arm[0] = 1'b1;
        tick();
        arm[0] = 1'b0;
        pb_mode[1:0] = 2'd0;
        chk("s3_abort", {63'd0, out_vld[0]}, 64'd0);
        chk("s3_armed", st(0), 64'(ST_ARMED));
        chk("s3_drain", 64'(exp_out.size()), 64'd0);

        // Scenario 2: wrap the 16-deep buffer, then play back once.
        post_trig_cnt = 4'd0;
        arm[0] = 1'b1;
        tick();
        arm[0] = 1'b0;
        for (int i = 0; i < 20; i++) word0(64'(i), i == 19);
        chk("s2_frozen", st(0), 64'(ST_FROZEN));
        chk("s2_wp", wp(0), 64'd4);
        chk("s2_wrap", {63'd0, wrapped[0]}, 64'd1);
        pb_mode[1:0] = 2'd1;
        pb_start[0]  = 1'b1;
        for (int i = 4; i < 20; i++) exp_out.push_back(64'(i));
        tick();
        pb_start[0]  = 1'b0;
        pb_mode[1:0] = 2'd2;
        tick();
        chk("s2_d1", {63'd0, out_vld[0]}, 64'd0);
        tick();
        chk("s2_first", {63'd0, out_vld[0]}, 64'd1);
        repeat (15) tick();
        chk("s2_back", st(0), 64'(ST_FROZEN));
        tick();
        chk("s2_end", {63'd0, out_vld[0]}, 64'd0);
        chk("s2_drain", 64'(exp_out.size()), 64'd0);
        pb_mode[1:0] = 2'd0;

        // Scenario 5: arm beats trig; trig in IDLE does nothing.
        post_trig_cnt = 4'd4;
        arm[1] = 1'b1;
        tick();
        arm[1] = 1'b0;
        for (int i = 0; i < 3; i++) begin
            mon_data[DATA_W +: DATA_W] = 64'(8'h11 + i);
            mon_vld[1] = 1'b1;
            tick();
        end
        mon_vld[1] = 1'b0;
        chk("s5_wp", wp(1), 64'd3);
        mon_data[DATA_W +: DATA_W] = 64'h99;
        mon_vld[1] = 1'b1;
        arm[1] = 1'b1;
        trig[1] = 1'b1;
        tick();
        mon_vld[1] = 1'b0;
        arm[1] = 1'b0;
        trig[1] = 1'b0;
        chk("s5_armtrig", st(1), 64'(ST_ARMED));
        chk("s5_clr", wp(1), 64'd0);
        tick();
        chk("s5_nopost", st(1), 64'(ST_ARMED));
        trig[2] = 1'b1;
        pb_start[2] = 1'b1;
        pb_mode[5:4] = 2'd1;
        tick();
        trig[2] = 1'b0;
        pb_start[2] = 1'b0;
        pb_mode[5:4] = 2'd0;
        chk("s5_idle", st(2), 64'(ST_IDLE));

        // Scenario 6: reset in POST, then reset in PLAY.
        post_trig_cnt = 4'd5;
        mon_data[DATA_W +: DATA_W] = 64'h55;
        mon_vld[1] = 1'b1;
        trig[1] = 1'b1;
        tick();
        mon_vld[1] = 1'b0;
        trig[1] = 1'b0;
        chk("s6_post", st(1), 64'(ST_POST));
        rst_hs = 1'b1;
        tick();
        rst_hs = 1'b0;
        chk("s6a_state", 64'(ch_state), 64'd0);
        chk("s6a_outv", 64'(out_vld), 64'd0);
        chk("s6a_wp", 64'(wr_ptr), 64'd0);
        post_trig_cnt = 4'd0;
        arm[0] = 1'b1;
        tick();
        arm[0] = 1'b0;
        word0(64'hA0, 1'b0);
        word0(64'hA1, 1'b0);
        word0(64'hA2, 1'b1);
        chk("s6_frozen", st(0), 64'(ST_FROZEN));
        pb_mode[1:0] = 2'd1;
        pb_start[0]  = 1'b1;
        tick();
        pb_start[0] = 1'b0;
        chk("s6_play", st(0), 64'(ST_PLAY));
        rst_hs = 1'b1;
        tick();
        rst_hs = 1'b0;
        pb_mode[1:0] = 2'd0;
        chk("s6b_state", 64'(ch_state), 64'd0);
        chk("s6b_outv", 64'(out_vld), 64'd0);
        chk("s6b_wp", 64'(wr_ptr), 64'd0);
        rd(0, 0, 64'hA0);
        rd(0, 1, 64'hA1);
        rd(0, 2, 64'hA2);
        rd(0, 5, 64'd5);
        rd(1, 0, 64'h55);
        rd(1, 2, 64'h13);
        tick();
        tick();
        chk("end_out_q", 64'(exp_out.size()), 64'd0);
        chk("end_rd_q", 64'(exp_rd.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fm_spy_capture.md
Name: fm_spy_capture

Overview:
- Multi-channel trigger-aware spy capture engine for the fast-monitoring (FM) path.
- Successor to the per-signal spy buffer with passthrough. Adds:
  - a per-channel arm/trigger/freeze state machine with programmable post-trigger depth;
  - oldest-first playback in one-shot or loop mode;
  - one shared random-access readout port.
- Sits between the user-logic monitor taps and the FM output/readout logic.
- Everything runs on one clock domain, clk_hs.

Parameters:
- N_CH, 4, number of monitored channels.
- DATA_W, 64, monitored word width.
- ADDR_W, 10, buffer address width; DEPTH = 2**ADDR_W.
- CH_W, $clog2(N_CH) (minimum 1), readout channel-select width.

Ports:
- clk_hs  in  1  clock.
- rst_hs  in  1  reset; synchronous, active-high.
- mon_data  in  N_CH*DATA_W  monitored data; channel c occupies bits [c*DATA_W +: DATA_W].
- mon_vld  in  N_CH  per-channel data valid.
- arm  in  N_CH  pulse: start (or restart) capture.
- trig  in  N_CH  pulse: trigger event.
- post_trig_cnt  in  ADDR_W  number of valid words captured after the trigger cycle; shared by all channels.
- pb_mode  in  2*N_CH  per channel: 0 = passthrough, 1 = playback once, 2 = playback loop, 3 = same as 0.
- pb_start  in  N_CH  pulse: start playback.
- rd_en  in  1  readout request.
- rd_ch  in  CH_W  readout channel select.
- rd_addr  in  ADDR_W  readout address.
- rd_data  out  DATA_W  readout data.
- rd_vld  out  1  readout data valid.
- out_data  out  N_CH*DATA_W  passthrough or playback data.
- out_vld  out  N_CH  output valid.
- ch_state  out  3*N_CH  per-channel state encoding.
- wr_ptr  out  N_CH*ADDR_W  next write address per channel.
- wrapped  out  N_CH  buffer has wrapped since the last arm.

Behaviour:
- Reset:
  - all channels go to IDLE;
  - wr_ptr, wrapped, post-trigger counter, playback pointer/count, rd_data, rd_vld, out_data and out_vld are all 0;
  - memory contents are not cleared.
- Per-channel states: IDLE=0, ARMED=1, POST=2, FROZEN=3, PLAY=4.
- IDLE:
  - arm -> ARMED; wr_ptr<=0, wrapped<=0.
  - trig and pb_start are ignored.
- ARMED:
  - each mon_vld writes mon_data to mem[wr_ptr], then wr_ptr increments modulo DEPTH.
  - When wr_ptr goes from DEPTH-1 to 0, wrapped<=1.
  - On trig, the word in that same cycle (if vld) is written. Then:
    - post_trig_cnt==0 -> FROZEN;
    - otherwise -> POST with cnt<=post_trig_cnt.
  - arm together with trig: arm wins; the channel restarts ARMED with pointers cleared.
- POST:
  - writes continue as in ARMED; each written word decrements cnt.
  - Writing the word that takes cnt to 0 moves the channel to FROZEN; that write completes.
  - trig is ignored (no retrigger).
  - arm restarts ARMED.
- FROZEN:
  - no writes.
  - pb_start with pb_mode in {1,2} -> PLAY, with:
    - start address = wrapped ? wr_ptr : 0;
    - count = wrapped ? DEPTH : wr_ptr.
  - If count==0 the channel stays FROZEN and emits nothing.
  - arm -> ARMED.
- PLAY:
  - reads one word per cycle from the oldest to the newest.
  - out_vld is high for exactly count consecutive cycles, starting 2 cycles after pb_start.
  - After the last word:
    - mode 1 -> FROZEN;
    - mode 2 -> restart from the start address with no idle gap.
  - arm aborts playback -> ARMED; the in-flight word is dropped and out_vld is 0 from the next cycle.
  - pb_mode is sampled at pb_start; changes during PLAY are ignored.
- Passthrough (every state except PLAY): out_data/out_vld = mon_data/mon_vld delayed by exactly 1 cycle. In PLAY, mon_data is not forwarded but capture is already stopped.
- Readout:
  - rd_en -> rd_data = mem[rd_ch][rd_addr] and rd_vld=1 one cycle later; otherwise rd_vld=0 and rd_data holds its value.
  - Readout is legal in every state. Reading a location being written in the same cycle returns the old data.
  - rd_ch >= N_CH returns rd_data=0 with rd_vld=1.
- Memory: simple dual-port per channel.
  - Port A: capture write / playback read; these are mutually exclusive by state.
  - Port B: readout.
  - Read latency is 1 cycle on both ports.

Decomposition:
- fm_sb_pkg gets:
  - the fm_cap_state_t enum (3 bits);
  - the fm_pb_mode_t enum: PB_PASS=0, PB_ONCE=1, PB_LOOP=2.
- One sub-module, fm_spy_capture_ch, holds the per-channel FSM, its memory and its output stage; it is instantiated N_CH times.
- The top level holds only the readout mux and the rd_data/rd_vld registers.

Test Plan:
1. Reset, then arm ch0, 5 valid words 1..5, trig on word 5, post_trig_cnt=3, words 6..8 -> ch_state=FROZEN after word 8; wr_ptr=8; wrapped=0; extra words are not written.
2. ADDR_W=4: arm, 20 valid words 0..19, trig on word 19 with post_trig_cnt=0 -> FROZEN, wr_ptr=4, wrapped=1; playback once emits 4..19 over 16 consecutive cycles starting 2 cycles after pb_start, then returns to FROZEN.
3. After scenario 1, pb_mode=2 plus pb_start -> continuous 1..8,1..8,…; arm mid-stream -> out_vld=0 the next cycle and state=ARMED.
4. Readout of ch0 addr 0..7 after scenario 1 -> rd_data 1..8, each 1 cycle after rd_en; rd_ch=N_CH -> rd_data=0, rd_vld=1.
5. arm and trig in the same cycle while ARMED -> pointers cleared, state=ARMED, no POST; trig while IDLE -> no state change.
6. rst_hs asserted in POST and again in PLAY -> next cycle: all states IDLE, out_vld=0, wr_ptr=0; a subsequent readout returns the pre-reset memory contents.
